word_mem: RTL

WORD_MEM -- requirements
Module: word_mem

---
 rtl/word_mem.sv | 91 +++++++++
 1 files changed

// File: rtl/word_mem.sv
// word_mem: single-port word memory with per-byte-lane write enables,
// registered read data with a one-cycle valid strobe, and an optional
// post-reset clear sequencer that zeroes the array one word per cycle.
module word_mem #(
    parameter int ADDRWIDTH      = 3,
    parameter int DEPTH          = 2**ADDRWIDTH,
    parameter int LANES          = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 CS,
    input  logic                 RW,
    input  logic [LANES-1:0]     BE,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [8*LANES-1:0]   din,
    output logic [8*LANES-1:0]   dout,
    output logic                 dvalid,
    output logic                 busy
);

    localparam int DW    = 8*LANES;
    localparam int WORDS = 2**ADDRWIDTH;
    localparam int CW    = $clog2(DEPTH+1);

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    localparam state_t              RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [ADDRWIDTH:0]  DEPTH_W   = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [CW-1:0]       LAST_PTR  = CW'(DEPTH-1);

    // Array spans the full address space so every address indexes cleanly;
    // words at or above DEPTH are never written nor read back.
    logic [DW-1:0]        mem [WORDS];

    state_t               state;
    logic [CW-1:0]        clr_ptr;
    logic [ADDRWIDTH-1:0] clr_idx;
    logic                 clr_last;
    logic                 rd_req;
    logic                 wr_req;
    logic                 in_range;

    // Access decode: anything other than a clean 0 on CS or a clean level on RW
    // is treated as deselected, so unknowns can never trigger an access.
    always_comb begin
        rd_req   = (CS === 1'b0) && (RW === 1'b1);
        wr_req   = (CS === 1'b0) && (RW === 1'b0);
        in_range = ({1'b0, addr} < DEPTH_W);
        clr_idx  = ADDRWIDTH'(clr_ptr);
        clr_last = (clr_ptr == LAST_PTR);
    end

    // Clear sequencer, read port and lane-masked write port. Storage shares the
    // reset-sensitive block so that an edge seen while rst_n is low can never
    // commit a write, while the stored words themselves are not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            busy    <= (RST_STATE == CLEAR);
            clr_ptr <= '0;
            dout    <= '0;
            dvalid  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[clr_idx] <= '0;
                    clr_ptr      <= clr_ptr + CW'(1);
                    dvalid       <= 1'b0;
                    if (clr_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    dvalid <= rd_req;
                    if (rd_req) begin
                        dout <= in_range ? mem[addr] : '0;
                    end else if (wr_req && in_range) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (BE[i]) begin
                                mem[addr][8*i +: 8] <= din[8*i +: 8];
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
